// File: rtl/lock_clear_board.sv
// Playfield storage for a falling-block game. Locks the falling piece into a
// 20x10 board, removes full rows one at a time by shifting the rows above
// down, and reports lines cleared and points earned for each lock.
//
// Handshake: lock_en is a single-cycle request that is accepted only while
// busy is low (FSM in IDLE). A request seen while busy is high is dropped.
// clear_done pulses for one cycle when the accepted lock has been fully
// processed. lines_cleared and score_add then hold until the next completion.
module lock_clear_board (
    input  logic        pclk,
    input  logic        rst,
    input  logic        lock_en,
    input  logic [3:0]  sq_1_col,
    input  logic [3:0]  sq_2_col,
    input  logic [3:0]  sq_3_col,
    input  logic [3:0]  sq_4_col,
    input  logic [4:0]  sq_1_row,
    input  logic [4:0]  sq_2_row,
    input  logic [4:0]  sq_3_row,
    input  logic [4:0]  sq_4_row,
    input  logic [4:0]  rd_row,
    output logic [9:0]  rd_data,
    output logic        collision,
    output logic        busy,
    output logic        clear_done,
    output logic [2:0]  lines_cleared,
    output logic [10:0] score_add,
    output logic        game_over,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        SCAN  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [9:0]  r_board [0:19];
    logic [4:0]  r_scan_row;
    logic [4:0]  r_shift_row;
    logic [2:0]  r_line_cnt;
    logic [2:0]  r_lines;
    logic [10:0] r_score;
    logic        r_clear_done;
    logic        r_game_over;
    logic [9:0]  r_rd_data;

    logic [3:0]  w_col   [0:3];
    logic [4:0]  w_row   [0:3];
    logic [4:0]  w_below [0:3];
    logic [3:0]  w_sq_ok;
    logic        w_collision;
    logic        w_top_hit;
    logic        w_row_full;

    function automatic logic [10:0] score_for(input logic [2:0] n);
        case (n)
            3'd1:    score_for = 11'd40;
            3'd2:    score_for = 11'd100;
            3'd3:    score_for = 11'd300;
            3'd4:    score_for = 11'd1200;
            default: score_for = 11'd0;
        endcase
    endfunction

    // Gather the four piece squares into arrays and flag the in-range ones.
    always_comb begin
        w_col[0] = sq_1_col;
        w_col[1] = sq_2_col;
        w_col[2] = sq_3_col;
        w_col[3] = sq_4_col;
        w_row[0] = sq_1_row;
        w_row[1] = sq_2_row;
        w_row[2] = sq_3_row;
        w_row[3] = sq_4_row;
        for (int i = 0; i < 4; i++) begin
            w_sq_ok[i] = (w_col[i] <= 4'd9) && (w_row[i] <= 5'd19);
            w_below[i] = w_row[i] + 5'd1;
        end
    end

    // Piece cannot fall: a square on the floor or resting on an occupied cell;
    // also detect a lock that touches the top row.
    always_comb begin
        w_collision = 1'b0;
        w_top_hit   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_sq_ok[i]) begin
                if (w_row[i] == 5'd19) begin
                    w_collision = 1'b1;
                end else if (r_board[w_below[i]][w_col[i]]) begin
                    w_collision = 1'b1;
                end
                if (w_row[i] == 5'd0) begin
                    w_top_hit = 1'b1;
                end
            end
        end
    end

    assign w_row_full = (r_board[r_scan_row] == 10'h3FF);

    // Next-state logic; SHIFT returns to SCAN at the same row so a row pulled
    // down into the cleared position gets re-checked.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (lock_en) w_next = WRITE;
            WRITE:   w_next = SCAN;
            SCAN: begin
                if (w_row_full)              w_next = SHIFT;
                else if (r_scan_row == 5'd0) w_next = DONE;
            end
            SHIFT:   if (r_shift_row == 5'd0) w_next = SCAN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Row pointers, line counter, result latches and sticky game-over flag.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_scan_row   <= 5'd0;
            r_shift_row  <= 5'd0;
            r_line_cnt   <= 3'd0;
            r_lines      <= 3'd0;
            r_score      <= 11'd0;
            r_clear_done <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                WRITE: begin
                    r_line_cnt <= 3'd0;
                    r_scan_row <= 5'd19;
                    if (w_top_hit) r_game_over <= 1'b1;
                end
                SCAN: begin
                    if (w_row_full) begin
                        if (r_line_cnt != 3'd4) r_line_cnt <= r_line_cnt + 3'd1;
                        r_shift_row <= r_scan_row;
                    end else if (r_scan_row != 5'd0) begin
                        r_scan_row <= r_scan_row - 5'd1;
                    end
                end
                SHIFT: begin
                    if (r_shift_row != 5'd0) r_shift_row <= r_shift_row - 5'd1;
                end
                DONE: begin
                    r_clear_done <= 1'b1;
                    r_lines      <= r_line_cnt;
                    r_score      <= score_for(r_line_cnt);
                end
                default: ;
            endcase
        end
    end

    // Board storage: piece write in WRITE, one-row downward copy per SHIFT cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int r = 0; r < 20; r++) r_board[r] <= 10'h000;
        end else begin
            case (r_state)
                WRITE: begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_sq_ok[i]) r_board[w_row[i]][w_col[i]] <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_shift_row != 5'd0) r_board[r_shift_row] <= r_board[r_shift_row - 5'd1];
                    else                     r_board[0] <= 10'h000;
                end
                default: ;
            endcase
        end
    end

    // Display read port, refreshed every cycle so shifting is visible.
    always_ff @(posedge pclk) begin
        if (rst)                  r_rd_data <= 10'h000;
        else if (rd_row <= 5'd19) r_rd_data <= r_board[rd_row];
        else                      r_rd_data <= 10'h000;
    end

    assign rd_data       = r_rd_data;
    assign collision     = w_collision;
    assign busy          = (r_state != IDLE);
    assign clear_done    = r_clear_done;
    assign lines_cleared = r_lines;
    assign score_add     = r_score;
    assign game_over     = r_game_over;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lock_clear_board.sv
// Directed bench for lock_clear_board. Locks push the expected
// {lines_cleared, score_add, completion cycle} into exp_q; a monitor pops and
// compares on every clear_done pulse.
module tb_lock_clear_board;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        lock_en = 1'b0;
    logic [3:0]  sq_1_col = '0, sq_2_col = '0, sq_3_col = '0, sq_4_col = '0;
    logic [4:0]  sq_1_row = '0, sq_2_row = '0, sq_3_row = '0, sq_4_row = '0;
    logic [4:0]  rd_row = '0;
    logic [9:0]  rd_data;
    logic        collision;
    logic        busy;
    logic        clear_done;
    logic [2:0]  lines_cleared;
    logic [10:0] score_add;
    logic        game_over;
    logic [2:0]  o_dbg_state;

    localparam int W = 34;
    logic [W-1:0] exp_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    lock_clear_board dut (
        .pclk          (pclk),
        .rst           (rst),
        .lock_en       (lock_en),
        .sq_1_col      (sq_1_col),
        .sq_2_col      (sq_2_col),
        .sq_3_col      (sq_3_col),
        .sq_4_col      (sq_4_col),
        .sq_1_row      (sq_1_row),
        .sq_2_row      (sq_2_row),
        .sq_3_row      (sq_3_row),
        .sq_4_row      (sq_4_row),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .collision     (collision),
        .busy          (busy),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .score_add     (score_add),
        .game_over     (game_over),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1;
        lock_en = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_sq(input logic [3:0] c1, input logic [4:0] r1,
                          input logic [3:0] c2, input logic [4:0] r2,
                          input logic [3:0] c3, input logic [4:0] r3,
                          input logic [3:0] c4, input logic [4:0] r4);
        sq_1_col = c1; sq_1_row = r1;
        sq_2_col = c2; sq_2_row = r2;
        sq_3_col = c3; sq_3_row = r3;
        sq_4_col = c4; sq_4_row = r4;
    endtask

    // Pulse lock_en for one cycle; optionally register the expected result.
    task automatic do_lock(input bit push, input logic [2:0] lines,
                           input logic [10:0] score, input int lat);
        int unsigned t0;
        @(negedge pclk);
        lock_en = 1'b1;
        @(posedge pclk);
        #1;
        t0 = cyc;
        if (push) exp_q.push_back({lines, score, 20'(t0 + lat)});
        @(negedge pclk);
        lock_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic lock(input logic [3:0] c1, input logic [4:0] r1,
                        input logic [3:0] c2, input logic [4:0] r2,
                        input logic [3:0] c3, input logic [4:0] r3,
                        input logic [3:0] c4, input logic [4:0] r4,
                        input logic [2:0] lines, input logic [10:0] score, input int lat);
        set_sq(c1, r1, c2, r2, c3, r3, c4, r4);
        do_lock(1'b1, lines, score, lat);
        wait_idle();
    endtask

    task automatic check_row(input string name, input logic [4:0] row, input logic [9:0] exp);
        rd_row = row;
        @(negedge pclk);
        check(name, int'(rd_data), int'(exp));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge pclk) begin
        logic [W-1:0] e;
        if (!rst && clear_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_clear_done: got pulse at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("lines_cleared", int'(lines_cleared), int'(e[33:31]));
                check("score_add", int'(score_add), int'(e[30:20]));
                check("done_cycle", int'(cyc[19:0]), int'(e[19:0]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;

        // Reset state
        do_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_clear_done", int'(clear_done), 0);
        check("rst_lines", int'(lines_cleared), 0);
        check("rst_score", int'(score_add), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_state", int'(o_dbg_state), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check_row("rst_row19", 5'd19, 10'h000);

        // O piece on the floor, no rows complete
        lock(4'd4, 5'd19, 4'd5, 5'd19, 4'd4, 5'd18, 4'd5, 5'd18, 3'd0, 11'd0, 22);
        check_row("o_row19", 5'd19, 10'h030);
        check_row("o_row18", 5'd18, 10'h030);
        check_row("o_row17", 5'd17, 10'h000);
        check("o_game_over", int'(game_over), 0);

        // Collision against that board
        set_sq(4'd4, 5'd17, 4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0); #1;
        check("coll_above_cell", int'(collision), 1);
        set_sq(4'd0, 5'd17, 4'd0, 5'd17, 4'd0, 5'd17, 4'd0, 5'd17); #1;
        check("coll_free", int'(collision), 0);
        set_sq(4'd0, 5'd19, 4'd0, 5'd16, 4'd0, 5'd16, 4'd0, 5'd16); #1;
        check("coll_floor", int'(collision), 1);
        set_sq(4'd12, 5'd19, 4'd12, 5'd19, 4'd4, 5'd25, 4'd4, 5'd16); #1;
        check("coll_out_of_range", int'(collision), 0);

        // Lock touching row 0 sets sticky game_over; board keeps updating
        lock(4'd4, 5'd0, 4'd5, 5'd0, 4'd4, 5'd1, 4'd5, 5'd1, 3'd0, 11'd0, 22);
        check("go_set", int'(game_over), 1);
        check_row("go_row0", 5'd0, 10'h030);
        lock(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19, 3'd0, 11'd0, 22);
        check("go_sticky", int'(game_over), 1);
        check_row("go_row19", 5'd19, 10'h03F);

        // Single clear at row 19 (one full rescan adds 21 cycles)
        do_reset();
        check("rst2_game_over", int'(game_over), 0);
        check_row("rst2_row0", 5'd0, 10'h000);
        lock(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19, 3'd0, 11'd0, 22);
        lock(4'd4, 5'd19, 4'd5, 5'd19, 4'd0, 5'd18, 4'd2, 5'd25, 3'd0, 11'd0, 22);
        check_row("pre1_row19", 5'd19, 10'h03F);
        check_row("pre1_row18", 5'd18, 10'h001);
        lock(4'd6, 5'd19, 4'd7, 5'd19, 4'd8, 5'd19, 4'd9, 5'd19, 3'd1, 11'd40, 43);
        check_row("clr1_row19", 5'd19, 10'h001);
        check_row("clr1_row18", 5'd18, 10'h000);
        repeat (3) @(negedge pclk);
        check("clr1_lines_held", int'(lines_cleared), 1);
        check("clr1_score_held", int'(score_add), 40);

        // Two clears with a square piece
        do_reset();
        lock(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19, 3'd0, 11'd0, 22);
        lock(4'd4, 5'd19, 4'd5, 5'd19, 4'd6, 5'd19, 4'd7, 5'd19, 3'd0, 11'd0, 22);
        lock(4'd0, 5'd18, 4'd1, 5'd18, 4'd2, 5'd18, 4'd3, 5'd18, 3'd0, 11'd0, 22);
        lock(4'd4, 5'd18, 4'd5, 5'd18, 4'd6, 5'd18, 4'd7, 5'd18, 3'd0, 11'd0, 22);
        lock(4'd8, 5'd18, 4'd9, 5'd18, 4'd8, 5'd19, 4'd9, 5'd19, 3'd2, 11'd100, 64);
        check_row("clr2_row19", 5'd19, 10'h000);
        check_row("clr2_row18", 5'd18, 10'h000);

        // Four clears with a vertical I at column 9
        do_reset();
        for (int r = 16; r < 20; r++) begin
            lock(4'd0, 5'(r), 4'd1, 5'(r), 4'd2, 5'(r), 4'd3, 5'(r), 3'd0, 11'd0, 22);
            lock(4'd4, 5'(r), 4'd5, 5'(r), 4'd6, 5'(r), 4'd7, 5'(r), 3'd0, 11'd0, 22);
        end
        lock(4'd8, 5'd16, 4'd8, 5'd17, 4'd8, 5'd18, 4'd8, 5'd19, 3'd0, 11'd0, 22);
        check_row("pre4_row16", 5'd16, 10'h1FF);
        lock(4'd9, 5'd16, 4'd9, 5'd17, 4'd9, 5'd18, 4'd9, 5'd19, 3'd4, 11'd1200, 106);
        for (int r = 0; r < 20; r++) check_row($sformatf("clr4_row%0d", r), 5'(r), 10'h000);

        // lock_en while busy is dropped
        do_reset();
        set_sq(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19);
        do_lock(1'b1, 3'd0, 11'd0, 22);
        repeat (5) @(negedge pclk);
        set_sq(4'd9, 5'd10, 4'd9, 5'd11, 4'd9, 5'd12, 4'd9, 5'd13);
        lock_en = 1'b1;
        @(negedge pclk);
        lock_en = 1'b0;
        wait_idle();
        repeat (30) @(negedge pclk);
        check("busy_lock_idle", int'(busy), 0);
        check_row("busy_row19", 5'd19, 10'h00F);
        check_row("busy_row10", 5'd10, 10'h000);

        // Reset in the middle of SHIFT abandons the lock
        do_reset();
        lock(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19, 3'd0, 11'd0, 22);
        lock(4'd4, 5'd19, 4'd5, 5'd19, 4'd0, 5'd18, 4'd1, 5'd18, 3'd0, 11'd0, 22);
        set_sq(4'd6, 5'd19, 4'd7, 5'd19, 4'd8, 5'd19, 4'd9, 5'd19);
        do_lock(1'b0, 3'd0, 11'd0, 0);
        n = 0;
        while (o_dbg_state != 3'd3 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("reached_shift", int'(o_dbg_state), 3);
        repeat (5) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        check("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        check("mid_rst_lines", int'(lines_cleared), 0);
        check("mid_rst_score", int'(score_add), 0);
        check("mid_rst_clear_done", int'(clear_done), 0);
        for (int r = 0; r < 20; r++) check_row($sformatf("mid_rst_row%0d", r), 5'(r), 10'h000);
        repeat (60) @(negedge pclk);
        check("mid_rst_stays_idle", int'(busy), 0);

        // Every registered expectation must have been consumed
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_clear_board.md
LOCK_CLEAR_BOARD -- requirements
Module: lock_clear_board

Interface
REQ-001 pclk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 lock_en  input  1  one-cycle request to write the falling piece into the board.
REQ-004 sq_1_col..sq_4_col  input  4 each  column of each piece square; valid 0..9.
REQ-005 sq_1_row..sq_4_row  input  5 each  row of each piece square; valid 0..19, row 0 at top.
REQ-006 rd_row  input  5  display read address.
REQ-007 rd_data  output  10  registered contents of board[rd_row]; bit n is column n.
REQ-008 collision  output  1  combinational; the piece cannot move down one row.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 clear_done  output  1  one-cycle pulse when lock processing completes.
REQ-011 lines_cleared  output  3  number of rows removed by the last lock, 0..4; held until the next lock.
REQ-012 score_add  output  11  points for the last lock; held until the next lock.
REQ-013 game_over  output  1  sticky flag.

Function
REQ-014 Storage SHALL be a 20x10-bit board register array; cell = 1 means occupied.
REQ-015 collision SHALL be 1 if any square has row==19 or board[row+1][col]==1; squares with col>9 or row>19 are ignored.
REQ-016 The FSM SHALL have states IDLE, WRITE, SCAN, SHIFT and DONE.
REQ-017 IDLE: lock_en==1 -> WRITE on the next edge; lock_en==0 -> remain in IDLE.
REQ-018 lock_en SHALL be ignored in every state other than IDLE; a lock requested while busy is lost.
REQ-019 WRITE (one cycle): set the 4 addressed cells; skip out-of-range squares; clear the line counter; set scan_row=19; -> SCAN.
REQ-020 WRITE SHALL set game_over if any in-range square has row==0.
REQ-021 SCAN (one row per cycle), when board[scan_row]==10'h3FF: increment the line counter, set shift_row=scan_row, -> SHIFT.
REQ-022 SCAN, when the row is not full and scan_row==0: -> DONE.
REQ-023 SCAN, when the row is not full and scan_row>0: decrement scan_row.
REQ-024 SHIFT (one row per cycle), shift_row>0: copy board[shift_row-1] into board[shift_row] and decrement shift_row.
REQ-025 SHIFT, shift_row==0: clear board[0] and return to SCAN at the unchanged scan_row, so a row pulled down into a cleared position is re-checked.
REQ-026 A single clear at row r SHALL occupy r+1 SHIFT cycles.
REQ-027 DONE (one cycle): pulse clear_done, latch lines_cleared and score_add, -> IDLE.
REQ-028 score_add SHALL be 0/40/100/300/1200 for 0/1/2/3/4 lines.
REQ-029 The line counter SHALL saturate at 4.
REQ-030 Latency with no full rows: clear_done SHALL be high in the cycle 22 edges after the edge that sampled lock_en.
REQ-031 rd_data SHALL be updated every cycle, including while busy; intermediate SHIFT contents are visible.
REQ-032 game_over SHALL stay 1 until rst; board updates SHALL continue regardless of game_over.

Reset
REQ-033 rst SHALL force the FSM to IDLE and clear the board, rd_data, busy, clear_done, lines_cleared, score_add and game_over to 0, with the same effect in every state.
REQ-034 A lock in progress when rst asserts SHALL be abandoned; the board after reset is empty.

Verification
REQ-035 Reset, then lock squares (4,19),(5,19),(4,18),(5,18) -> board[19]=board[18]=10'h030, clear_done at +22 cycles, lines_cleared=0, score_add=0.
REQ-036 Preload row 19 with columns 0..5, then lock an I piece at row 19 cols 6..9 -> row 19 removed, lines_cleared=1, score_add=40, board[19]=previous board[18].
REQ-037 Rows 16..18 preset to 10'h1FF, then lock a vertical I at col 9, rows 16..19 with row 19 also 10'h1FF -> lines_cleared=4, score_add=1200, board all zero.
REQ-038 Piece at rows 0..1 locked -> game_over=1 and stays 1; collision=1 when a square sits above an occupied cell or at row 19.
REQ-039 lock_en pulsed while busy -> ignored, no extra clear_done.
REQ-040 rst asserted mid-SHIFT -> busy=0 next cycle and every rd_data row reads 0.
